// File: rtl/tdm2_if.sv
// Parallel-side bundle for the 2-channel TDM receiver: serial bit, qualifier, frame sync
// in; reassembled words, valid pulses and error flags out.
interface tdm2_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             d;
    logic             fs;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             va;
    logic             vb;
    logic             s;
    logic             err;
    logic             perr;

    modport master (
        output en, d, fs,
        input  a, b, va, vb, s, err, perr
    );

    modport slave (
        input  en, d, fs,
        output a, b, va, vb, s, err, perr
    );
endinterface

// File: rtl/tdm2_demux.sv
// 2-channel TDM serial demux: frame-aligns on fs, reassembles A then B words (MSB first).
// Latency: word and valid pulse appear the cycle after the en cycle carrying its last bit.
// No backpressure: en qualifies each bit; TDM2_PARITY_EN adds a trailing even-parity bit.
module tdm2_demux #(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    tdm2_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV_A,
`ifdef TDM2_PARITY_EN
        RECV_B,
        PAR
`else
        RECV_B
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [WIDTH-1:0] a_r, a_nxt;
    logic [WIDTH-1:0] b_r, b_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             va_r, va_nxt;
    logic             vb_r, vb_nxt;
    logic             err_r, err_nxt;
    logic             s_r, s_nxt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] first;
    logic             last;
`ifdef TDM2_PARITY_EN
    logic             perr_r, perr_nxt;
`endif

    assign word  = {sh[WIDTH-2:0], bus.d};
    assign first = {{(WIDTH-1){1'b0}}, bus.d};
    assign last  = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
        a_nxt     = a_r;
        b_nxt     = b_r;
        va_nxt    = 1'b0;
        vb_nxt    = 1'b0;
        err_nxt   = 1'b0;
`ifdef TDM2_PARITY_EN
        perr_nxt  = 1'b0;
`endif
        if (bus.en) begin
            case (state)
                IDLE: begin
                    if (bus.fs) begin
                        sh_nxt    = first;
                        cnt_nxt   = CW'(1);
                        state_nxt = RECV_A;
                    end
                end
                RECV_A, RECV_B: begin
                    // fs mid-frame aborts the partial word and starts a fresh frame on this bit
                    if (bus.fs) begin
                        err_nxt   = 1'b1;
                        sh_nxt    = first;
                        cnt_nxt   = CW'(1);
                        state_nxt = RECV_A;
                    end else if (last) begin
                        sh_nxt  = word;
                        cnt_nxt = '0;
                        if (state == RECV_A) begin
                            a_nxt     = word;
                            va_nxt    = 1'b1;
                            state_nxt = RECV_B;
                        end else begin
`ifdef TDM2_PARITY_EN
                            state_nxt = PAR;
`else
                            b_nxt     = word;
                            vb_nxt    = 1'b1;
                            state_nxt = IDLE;
`endif
                        end
                    end else begin
                        sh_nxt  = word;
                        cnt_nxt = cnt + 1'b1;
                    end
                end
`ifdef TDM2_PARITY_EN
                PAR: begin
                    if (bus.fs) begin
                        err_nxt   = 1'b1;
                        sh_nxt    = first;
                        cnt_nxt   = CW'(1);
                        state_nxt = RECV_A;
                    end else begin
                        // B is held in sh until the parity bit confirms the frame
                        b_nxt     = sh;
                        vb_nxt    = 1'b1;
                        perr_nxt  = ^{a_r, sh, bus.d};
                        state_nxt = IDLE;
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
`ifdef TDM2_PARITY_EN
        s_nxt = (state_nxt == RECV_B) || (state_nxt == PAR);
`else
        s_nxt = (state_nxt == RECV_B);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            va_r  <= 1'b0;
            vb_r  <= 1'b0;
            err_r <= 1'b0;
            s_r   <= 1'b0;
`ifdef TDM2_PARITY_EN
            perr_r <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            cnt   <= cnt_nxt;
            a_r   <= a_nxt;
            b_r   <= b_nxt;
            va_r  <= va_nxt;
            vb_r  <= vb_nxt;
            err_r <= err_nxt;
            s_r   <= s_nxt;
`ifdef TDM2_PARITY_EN
            perr_r <= perr_nxt;
`endif
        end
    end

    assign bus.a   = a_r;
    assign bus.b   = b_r;
    assign bus.va  = va_r;
    assign bus.vb  = vb_r;
    assign bus.s   = s_r;
    assign bus.err = err_r;
`ifdef TDM2_PARITY_EN
    assign bus.perr = perr_r;
`else
    assign bus.perr = 1'b0;
`endif
endmodule

// File: tb/tb_tdm2_demux.sv
// Directed bench for tdm2_demux (WIDTH=8); expectations hand-derived from the frame timing.
module tb_tdm2_demux;
`ifdef TDM2_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // per-frame observation counters
    int cyc, va_cyc, vb_cyc, va_n, vb_n, err_n, both_n, perr_at_vb;

    tdm2_if #(.WIDTH(8)) bus ();

    tdm2_demux #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        cyc++;
        if (bus.va === 1'b1) begin
            va_n++;
            if (va_cyc < 0) va_cyc = cyc;
        end
        if (bus.vb === 1'b1) begin
            vb_n++;
            if (vb_cyc < 0) vb_cyc = cyc;
            perr_at_vb = int'(bus.perr);
        end
        if (bus.err === 1'b1) err_n++;
        if (bus.va === 1'b1 && bus.vb === 1'b1) both_n++;
    endtask

    task automatic send(input logic d, input logic fs);
        bus.en = 1'b1;
        bus.d  = d;
        bus.fs = fs;
        tick();
    endtask

    // Sends a full frame; 3 idle (en=0) cycles follow bit index ga and gb (-1 = none).
    task automatic run_frame(input string tag, input logic [7:0] wa, input logic [7:0] wb,
                             input int ga, input int gb, input logic pbit, input int exp_err);
        logic [15:0] bits;
        int s_bad;
        int va_exp, vb_exp;
        logic exp_s;
        bits = {wa, wb};
        s_bad = 0;
        cyc = 0; va_cyc = -1; vb_cyc = -1; va_n = 0; vb_n = 0; err_n = 0; both_n = 0;
        perr_at_vb = -1;
        for (int i = 0; i < 16; i++) begin
            send(bits[15-i], i == 0);
            observe();
            exp_s = (i >= 7 && i < 15) ? 1'b1 : ((i == 15) ? PAR[0] : 1'b0);
            if (bus.s !== exp_s) s_bad++;
            if (i == ga || i == gb) begin
                for (int k = 0; k < 3; k++) begin
                    bus.en = 1'b0;
                    bus.d  = 1'($urandom_range(0, 1));
                    bus.fs = 1'($urandom_range(0, 1));
                    tick();
                    observe();
                end
            end
        end
`ifdef TDM2_PARITY_EN
        send(pbit, 1'b0);
        observe();
        if (bus.s !== 1'b0) s_bad++;
`endif
        va_exp = 8 + ((ga >= 0 && ga < 7) ? 3 : 0) + ((gb >= 0 && gb < 7) ? 3 : 0);
        vb_exp = 16 + PAR + ((ga >= 0 && ga < 15) ? 3 : 0) + ((gb >= 0 && gb < 15) ? 3 : 0);
        chk({tag, ".va_cycle"}, va_cyc, va_exp);
        chk({tag, ".vb_cycle"}, vb_cyc, vb_exp);
        chk({tag, ".a"}, bus.a, wa);
        chk({tag, ".b"}, bus.b, wb);
        chk({tag, ".va_count"}, va_n, 1);
        chk({tag, ".vb_count"}, vb_n, 1);
        chk({tag, ".err_count"}, err_n, exp_err);
        chk({tag, ".va_vb_overlap"}, both_n, 0);
        chk({tag, ".s_track"}, s_bad, 0);
        chk({tag, ".perr"}, perr_at_vb, (PAR == 1) ? int'(^{wa, wb, pbit}) : 0);
    endtask

    initial begin
        bus.en = 1'b0;
        bus.d  = 1'b0;
        bus.fs = 1'b0;

        // reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.en = 1'($urandom_range(0, 1));
            bus.d  = 1'($urandom_range(0, 1));
            bus.fs = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst.a", bus.a, 8'h00);
        chk("rst.b", bus.b, 8'h00);
        chk("rst.va", bus.va, 0);
        chk("rst.vb", bus.vb, 0);
        chk("rst.err", bus.err, 0);
        chk("rst.perr", bus.perr, 0);
        chk("rst.s", bus.s, 0);
        rst = 1'b0;
        bus.en = 1'b0;
        tick();

        // continuous frame, then a gapped frame sent back-to-back
        run_frame("cont", 8'hA5, 8'h3C, -1, -1, 1'b0, 0);
        run_frame("gap", 8'hA5, 8'h3C, 3, 10, 1'b0, 0);

        // fs idle bits in IDLE are ignored without error
        bus.en = 1'b1; bus.fs = 1'b0; bus.d = 1'b1;
        tick();
        chk("idle.err", bus.err, 0);
        chk("idle.s", bus.s, 0);

        // framing error: 4 bits of an A word, fs re-asserted on bit 5 starting a full frame
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("abort.err_before", bus.err, 0);
        run_frame("ferr", 8'h0F, 8'hF0, -1, -1, 1'b1, 1);

        // reset mid-frame during bit 3 of B
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h5A;
            send(w[7-i], i == 0);
        end
        chk("pre_rst.a", bus.a, 8'h5A);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        rst = 1'b1;
        send(1'b1, 1'b0);
        rst = 1'b0;
        chk("mid_rst.a", bus.a, 8'h00);
        chk("mid_rst.b", bus.b, 8'h00);
        chk("mid_rst.s", bus.s, 0);
        chk("mid_rst.va", bus.va, 0);
        run_frame("post_rst", 8'h81, 8'h18, -1, -1, 1'b0, 0);

        // parity-bit variants, back-to-back
        run_frame("par0", 8'hA5, 8'h3C, -1, -1, 1'b0, 0);
        run_frame("par1", 8'hA5, 8'h3C, -1, -1, 1'b1, 0);
        run_frame("b2b", 8'hC3, 8'h96, -1, -1, 1'b1, 0);

        // pulses self-clear with en low
        bus.en = 1'b0;
        tick();
        chk("idle_end.vb", bus.vb, 0);
        chk("idle_end.perr", bus.perr, 0);
        chk("idle_end.b", bus.b, 8'h96);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
